// File: rtl/rdma_sq_wrr_credit_arbiter.sv
// Weighted round-robin merge of per-region RDMA send queues into one network SQ,
// with per-region outstanding-request credits returned by vfid-routed CQ acks.
module rdma_sq_wrr_credit_arbiter #(
    parameter int N_REGIONS = 4,
    parameter int SQ_BITS   = 128,
    parameter int CQ_BITS   = 32,
    parameter int W_BITS    = 4,
    parameter int MAX_OUTST = 16,
    parameter int DROP_BITS = 16,
    localparam int VW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1,
    localparam int CW = $clog2(MAX_OUTST + 1)
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [N_REGIONS*W_BITS-1:0]   cfg_weight,
    input  logic [N_REGIONS-1:0]          s_sq_valid,
    output logic [N_REGIONS-1:0]          s_sq_ready,
    input  logic [N_REGIONS*SQ_BITS-1:0]  s_sq_data,
    output logic                          m_sq_valid,
    input  logic                          m_sq_ready,
    output logic [SQ_BITS-1:0]            m_sq_data,
    output logic [VW-1:0]                 vfid_tx,
    input  logic                          s_cq_valid,
    output logic                          s_cq_ready,
    input  logic [CQ_BITS-1:0]            s_cq_data,
    input  logic [3:0]                    s_cq_vfid,
    output logic [N_REGIONS-1:0]          m_cq_valid,
    input  logic [N_REGIONS-1:0]          m_cq_ready,
    output logic [CQ_BITS-1:0]            m_cq_data,
    output logic [N_REGIONS*CW-1:0]       outst_cnt,
    output logic [DROP_BITS-1:0]          cq_drop_cnt
);

    typedef enum logic {ST_ARB, ST_HOLD} state_e;

    state_e                state_q, state_d;
    logic [VW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [VW-1:0]         cur_q, cur_d;
    logic [W_BITS-1:0]     quota_q, quota_d;
    logic [CW-1:0]         outst_q [N_REGIONS];
    logic [CW-1:0]         outst_d [N_REGIONS];
    logic [DROP_BITS-1:0]  drop_q, drop_d;

    logic [N_REGIONS-1:0]  elig, sq_hs, cq_hit, cq_hs;
    logic                  any_elig, sq_fire, cq_in_range;
    logic [VW-1:0]         idx, sel, p_v;
    logic [W_BITS-1:0]     w_eff;
    int                    p;

    function automatic logic [VW-1:0] wrap_inc(input logic [VW-1:0] v);
        if (int'(v) >= N_REGIONS - 1) return '0;
        return v + VW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < N_REGIONS; i++) begin
            elig[i] = s_sq_valid[i] && (outst_q[i] < CW'(MAX_OUTST));
        end
    end
    assign any_elig = |elig;

    // Scan from the highest rotation down so the last hit is the one nearest rr_ptr.
    always_comb begin
        idx = '0;
        p   = 0;
        p_v = '0;
        for (int k = N_REGIONS - 1; k >= 0; k--) begin
            p = int'(rr_ptr_q) + k;
            if (p >= N_REGIONS) p = p - N_REGIONS;
            p_v = VW'(p);
            if (elig[p_v]) idx = p_v;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cur_d    = cur_q;
        quota_d  = quota_q;

        sel        = (state_q == ST_HOLD) ? cur_q : idx;
        m_sq_valid = (state_q == ST_HOLD) ? elig[cur_q] : any_elig;
        vfid_tx    = sel;
        m_sq_data  = s_sq_data[int'(sel)*SQ_BITS +: SQ_BITS];
        sq_fire    = m_sq_valid && m_sq_ready;
        for (int i = 0; i < N_REGIONS; i++) begin
            s_sq_ready[i] = sq_fire && (int'(sel) == i);
        end

        w_eff = cfg_weight[int'(sel)*W_BITS +: W_BITS];
        if (w_eff == '0) w_eff = W_BITS'(1);

        unique case (state_q)
            ST_ARB: begin
                if (any_elig) begin
                    if (sq_fire && w_eff <= W_BITS'(1)) begin
                        rr_ptr_d = wrap_inc(idx);
                    end else begin
                        // Enter HOLD even when not accepted so the offer cannot move.
                        cur_d   = idx;
                        quota_d = sq_fire ? (w_eff - W_BITS'(1)) : w_eff;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!elig[cur_q]) begin
                    state_d  = ST_ARB;
                    rr_ptr_d = wrap_inc(cur_q);
                end else if (sq_fire) begin
                    quota_d = quota_q - W_BITS'(1);
                    if (quota_q <= W_BITS'(1)) begin
                        state_d  = ST_ARB;
                        rr_ptr_d = wrap_inc(cur_q);
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_comb begin
        cq_in_range = int'(s_cq_vfid) < N_REGIONS;
        for (int i = 0; i < N_REGIONS; i++) begin
            cq_hit[i] = (int'(s_cq_vfid) == i);
        end
        m_cq_valid = cq_hit & {N_REGIONS{s_cq_valid}};
        m_cq_data  = s_cq_data;
        s_cq_ready = cq_in_range ? |(m_cq_ready & cq_hit) : 1'b1;
        cq_hs      = m_cq_valid & m_cq_ready;
        sq_hs      = s_sq_valid & s_sq_ready;

        drop_d = drop_q;
        if (s_cq_valid && !cq_in_range && drop_q != '1) drop_d = drop_q + DROP_BITS'(1);

        for (int i = 0; i < N_REGIONS; i++) begin
            outst_d[i] = outst_q[i];
            case ({sq_hs[i], cq_hs[i]})
                2'b10:   outst_d[i] = outst_q[i] + CW'(1);
                2'b01:   if (outst_q[i] != '0) outst_d[i] = outst_q[i] - CW'(1);
                default: outst_d[i] = outst_q[i];
            endcase
            outst_cnt[i*CW +: CW] = outst_q[i];
        end
        cq_drop_cnt = drop_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= ST_ARB;
            rr_ptr_q <= '0;
            cur_q    <= '0;
            quota_q  <= '0;
            drop_q   <= '0;
            // NOTE: the credit array is a handful of counters, not a memory, so it is
            // reset like any other register.
            for (int i = 0; i < N_REGIONS; i++) outst_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cur_q    <= cur_d;
            quota_q  <= quota_d;
            drop_q   <= drop_d;
            for (int i = 0; i < N_REGIONS; i++) outst_q[i] <= outst_d[i];
        end
    end

endmodule

// File: tb/tb_rdma_sq_wrr_credit_arbiter.sv
// Directed bench: expected grants go to a scoreboard queue, a monitor pops them on each
// network-SQ handshake; counters and CQ routing are compared directly.
module tb_rdma_sq_wrr_credit_arbiter;

    localparam int N  = 4;
    localparam int SB = 128;
    localparam int CB = 32;
    localparam int WB = 4;
    localparam int CW = 5;

    logic              aclk = 1'b0;
    logic              areset;
    logic [N*WB-1:0]   cfg_weight;
    logic [N-1:0]      s_sq_valid, s_sq_ready;
    logic [N*SB-1:0]   s_sq_data;
    logic              m_sq_valid, m_sq_ready;
    logic [SB-1:0]     m_sq_data;
    logic [1:0]        vfid_tx;
    logic              s_cq_valid, s_cq_ready;
    logic [CB-1:0]     s_cq_data;
    logic [3:0]        s_cq_vfid;
    logic [N-1:0]      m_cq_valid, m_cq_ready;
    logic [CB-1:0]     m_cq_data;
    logic [N*CW-1:0]   outst_cnt;
    logic [15:0]       cq_drop_cnt;

    rdma_sq_wrr_credit_arbiter dut (
        .aclk(aclk), .areset(areset), .cfg_weight(cfg_weight),
        .s_sq_valid(s_sq_valid), .s_sq_ready(s_sq_ready), .s_sq_data(s_sq_data),
        .m_sq_valid(m_sq_valid), .m_sq_ready(m_sq_ready), .m_sq_data(m_sq_data),
        .vfid_tx(vfid_tx),
        .s_cq_valid(s_cq_valid), .s_cq_ready(s_cq_ready), .s_cq_data(s_cq_data),
        .s_cq_vfid(s_cq_vfid),
        .m_cq_valid(m_cq_valid), .m_cq_ready(m_cq_ready), .m_cq_data(m_cq_data),
        .outst_cnt(outst_cnt), .cq_drop_cnt(cq_drop_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [1:0]    vf;
        logic [SB-1:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   errors  = 0;

    function automatic logic [SB-1:0] dat(input int r);
        return {64'h0, 32'h5A5A_0000 + 32'(r), 32'hDA7A_0000 + 32'(r)};
    endfunction

    task automatic check(input string name, input logic [SB-1:0] act, input logic [SB-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input int r);
        sb.push_back('{vf: 2'(r), d: dat(r)});
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        s_sq_valid = '0;
        m_sq_ready = 1'b0;
        s_cq_valid = 1'b0;
        s_cq_vfid  = '0;
        s_cq_data  = '0;
        m_cq_ready = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        areset = 1'b1;
        run(1);
        areset = 1'b0;
    endtask

    always @(negedge aclk) begin
        if (!areset && m_sq_valid && m_sq_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_grant: got vfid %0d, required no grant", vfid_tx);
            end else begin
                mon_e = sb.pop_front();
                check("grant_vfid", {126'h0, vfid_tx}, {126'h0, mon_e.vf});
                check("grant_data", m_sq_data, mon_e.d);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) s_sq_data[i*SB +: SB] = dat(i);
        cfg_weight = 16'h1111;
        idle_inputs();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("rst_m_sq_valid", {127'h0, m_sq_valid}, '0);
        check("rst_s_sq_ready", {124'h0, s_sq_ready}, '0);
        check("rst_m_cq_valid", {124'h0, m_cq_valid}, '0);
        check("rst_vfid_tx",    {126'h0, vfid_tx}, '0);
        check("rst_outst_cnt",  {108'h0, outst_cnt}, '0);
        check("rst_drop_cnt",   {112'h0, cq_drop_cnt}, '0);
        check("rst_s_cq_ready", {127'h0, s_cq_ready}, '0);
        run(1);
        areset = 1'b0;

        // Equal weights: plain round robin, one grant per cycle.
        cfg_weight = 16'h1111;
        s_sq_valid = 4'hF;
        m_sq_ready = 1'b1;
        for (int k = 0; k < 8; k++) push(k % 4);
        run(8);
        s_sq_valid = '0;
        check("rr_drain", 128'(sb.size()), '0);

        // Weights r0=3 r1=1 r2=0(->1) r3=2.
        do_reset();
        cfg_weight = 16'h2013;
        s_sq_valid = 4'hF;
        m_sq_ready = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            push(0); push(0); push(0); push(1); push(2); push(3); push(3);
        end
        run(14);
        s_sq_valid = '0;
        check("wrr_drain", 128'(sb.size()), '0);

        // Credit exhaustion on region 0 and release by one CQ ack.
        do_reset();
        cfg_weight = 16'h1111;
        s_sq_valid = 4'b0001;
        m_sq_ready = 1'b1;
        for (int k = 0; k < 16; k++) push(0);
        run(16);
        check("cred_full_r0", 128'(outst_cnt[0 +: CW]), 128'd16);
        s_sq_valid = 4'b0011;
        push(1); push(1);
        run(2);
        s_sq_valid = 4'b0001;
        check("cred_r1", 128'(outst_cnt[CW +: CW]), 128'd2);
        @(negedge aclk);
        check("cred_blocked", {127'h0, m_sq_valid}, '0);
        run(1);
        s_cq_valid = 1'b1;
        s_cq_vfid  = 4'd0;
        s_cq_data  = 32'hC0DE_0000;
        m_cq_ready = 4'hF;
        push(0);
        @(negedge aclk);
        check("cq0_no_sq_yet", {127'h0, m_sq_valid}, '0);
        check("cq0_m_valid",   {124'h0, m_cq_valid}, 128'h1);
        check("cq0_s_ready",   {127'h0, s_cq_ready}, 128'h1);
        check("cq0_data",      {96'h0, m_cq_data}, 128'hC0DE_0000);
        run(1);
        s_cq_valid = 1'b0;
        check("cred_r0_15", 128'(outst_cnt[0 +: CW]), 128'd15);
        @(negedge aclk);
        check("cred_r0_elig", {127'h0, m_sq_valid}, 128'h1);
        run(1);
        s_sq_valid = '0;
        check("cred_r0_16", 128'(outst_cnt[0 +: CW]), 128'd16);
        check("cred_drain", 128'(sb.size()), '0);

        // Stalled offer on region 2 stays put while region 1 also requests.
        do_reset();
        cfg_weight = 16'h1111;
        s_sq_valid = 4'b0100;
        m_sq_ready = 1'b0;
        run(1);
        s_sq_valid = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check("stall_vfid",  {126'h0, vfid_tx}, 128'd2);
            check("stall_valid", {127'h0, m_sq_valid}, 128'h1);
            check("stall_data",  m_sq_data, dat(2));
        end
        check("stall_s_ready", {124'h0, s_sq_ready}, '0);
        run(1);
        m_sq_ready = 1'b1;
        push(2);
        run(1);
        s_sq_valid = '0;
        m_sq_ready = 1'b0;
        check("stall_drain", 128'(sb.size()), '0);

        // CQ routing: out-of-range drop, then a stalled in-range ack.
        do_reset();
        s_cq_valid = 1'b1;
        s_cq_vfid  = 4'd7;
        s_cq_data  = 32'hACE0_0007;
        m_cq_ready = '0;
        @(negedge aclk);
        check("drop_s_ready", {127'h0, s_cq_ready}, 128'h1);
        check("drop_m_valid", {124'h0, m_cq_valid}, '0);
        run(1);
        check("drop_cnt_1", {112'h0, cq_drop_cnt}, 128'd1);
        s_cq_vfid  = 4'd1;
        m_cq_ready = 4'b1101;
        @(negedge aclk);
        check("cq1_stall_ready", {127'h0, s_cq_ready}, '0);
        check("cq1_m_valid",     {124'h0, m_cq_valid}, 128'h2);
        run(1);
        check("drop_cnt_hold", {112'h0, cq_drop_cnt}, 128'd1);
        m_cq_ready = 4'hF;
        run(1);
        s_cq_valid = 1'b0;
        check("cq1_sat_zero", 128'(outst_cnt[CW +: CW]), '0);

        // Same-cycle issue and return on region 3.
        do_reset();
        cfg_weight = 16'h1111;
        m_sq_ready = 1'b1;
        s_sq_valid = 4'b1000;
        push(3);
        run(1);
        s_sq_valid = '0;
        check("r3_issue", 128'(outst_cnt[3*CW +: CW]), 128'd1);
        s_sq_valid = 4'b1000;
        s_cq_valid = 1'b1;
        s_cq_vfid  = 4'd3;
        m_cq_ready = 4'hF;
        push(3);
        run(1);
        s_sq_valid = '0;
        check("r3_same_cycle", 128'(outst_cnt[3*CW +: CW]), 128'd1);
        run(1);
        s_cq_valid = 1'b0;
        check("r3_return", 128'(outst_cnt[3*CW +: CW]), '0);
        check("r3_drain", 128'(sb.size()), '0);

        // Reset while holding region 0 (weight 3) after its first grant.
        do_reset();
        cfg_weight = 16'h0003;
        m_sq_ready = 1'b1;
        s_sq_valid = 4'b0001;
        push(0);
        run(1);
        s_sq_valid = '0;
        areset = 1'b1;
        #1;
        check("midrst_outst", {108'h0, outst_cnt}, '0);
        check("midrst_valid", {127'h0, m_sq_valid}, '0);
        check("midrst_vfid",  {126'h0, vfid_tx}, '0);
        run(1);
        areset = 1'b0;
        s_sq_valid = 4'b0011;
        push(0); push(0); push(0); push(1);
        run(4);
        s_sq_valid = '0;
        check("midrst_drain", 128'(sb.size()), '0);
        check("midrst_counts", {108'h0, outst_cnt}, 128'h23);

        run(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
